// File: rtl/bcrypt_hash_parser_pkg.sv
// Shared types and slot geometry for the bcrypt modular-crypt string parser.
package bcrypt_hash_parser_pkg;

  typedef enum logic [2:0] {
    S_PFX,
    S_COST,
    S_SEP,
    S_SALT,
    S_CTXT,
    S_DONE,
    S_ERR
  } parse_state_e;

  localparam int PFX_LEN    = 4;
  localparam int COST_LEN   = 2;
  localparam int SALT_CHARS = 22;
  localparam int CTXT_CHARS = 31;
  localparam int STR_LEN    = 60;
  localparam int HASH_W     = 326;

  // Byte indices that close each slot of the string
  localparam logic [5:0] IDX_PFX_LAST   = 6'(PFX_LEN - 1);
  localparam logic [5:0] IDX_COST_FIRST = 6'(PFX_LEN);
  localparam logic [5:0] IDX_COST_LAST  = 6'(PFX_LEN + COST_LEN - 1);
  localparam logic [5:0] IDX_SALT_LAST  = 6'(PFX_LEN + COST_LEN + SALT_CHARS);
  localparam logic [5:0] IDX_LAST       = 6'(STR_LEN - 1);

endpackage

// File: rtl/bcrypt_hash_parser_if.sv
// Byte-stream input and parsed-result bundle between the UART side and the parser.
interface bcrypt_hash_parser_if;
  import bcrypt_hash_parser_pkg::*;

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [HASH_W-1:0] hash_o;
  logic              done;
  logic              err;
  logic [5:0]        err_pos;

  modport master (
    output in_valid, in_data,
    input  in_ready, hash_o, done, err, err_pos
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, hash_o, done, err, err_pos
  );
endinterface

// File: rtl/bcrypt_hash_parser_b64_dec.sv
// Combinational bcrypt-alphabet decoder: './0-9A-Za-z' -> 0..63, ok=0 for anything else.
module bcrypt_b64_dec (
  input  logic [7:0] ch,
  output logic       ok,
  output logic [5:0] val
);

  // Each alphabet run is contiguous in ASCII, so a 6-bit offset subtraction maps it directly
  always_comb begin
    ok  = 1'b0;
    val = '0;
    if (ch >= 8'h2E && ch <= 8'h39) begin
      ok  = 1'b1;
      val = ch[5:0] - 6'h2E;
    end else if (ch >= 8'h41 && ch <= 8'h5A) begin
      ok  = 1'b1;
      val = ch[5:0] - 6'h35;
    end else if (ch >= 8'h61 && ch <= 8'h7A) begin
      ok  = 1'b1;
      val = ch[5:0] - 6'h3B;
    end
  end

endmodule

// File: rtl/bcrypt_hash_parser.sv
// Byte-serial decoder of "$2a$NN$<salt22><ctext31>" into {cost, salt, ctext, 8'h00}.
module bcrypt_hash_parser
  import bcrypt_hash_parser_pkg::*;
#(
  parameter int MIN_COST = 4,
  parameter int MAX_COST = 31
) (
  input logic                 clk,
  input logic                 int_rst_l,
  input logic                 clr,
  bcrypt_hash_parser_if.slave bus
);

  parse_state_e      state;
  logic [5:0]        idx;
  logic [6:0]        cost_acc;
  logic [131:0]      salt_sr;
  logic [185:0]      ctxt_sr;
  logic              fin_pend;
  logic              fin_bad;
  logic [HASH_W-1:0] hash_r;
  logic              done_r;
  logic              err_r;
  logic [5:0]        err_pos_r;
  logic              ready_r;

  logic              b64_ok;
  logic [5:0]        b64_val;
  logic              is_digit;
  logic [3:0]        digit;
  logic              accept;
  logic              byte_bad;

  bcrypt_b64_dec u_b64_dec (
    .ch  (bus.in_data),
    .ok  (b64_ok),
    .val (b64_val)
  );

  assign is_digit = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
  assign digit    = bus.in_data[3:0];
  assign accept   = bus.in_valid && ready_r;

  // Decide whether the byte on the bus is illegal for the slot it would fill; the cost
  // accumulator is 7 bits wide so costs up to 99 are range-checked rather than wrapped.
  // A bad final ctext byte is reported one cycle later together with the pad check.
  always_comb begin
    byte_bad = 1'b0;
    case (state)
      S_PFX: begin
        case (idx)
          6'd0, 6'd3: byte_bad = (bus.in_data != 8'h24);
          6'd1:       byte_bad = (bus.in_data != 8'h32);
          default:    byte_bad = !((bus.in_data == 8'h61) || (bus.in_data == 8'h62));
        endcase
      end
      S_COST: byte_bad = !is_digit;
      S_SEP:  byte_bad = (bus.in_data != 8'h24) || (cost_acc < 7'(MIN_COST))
                         || (cost_acc > 7'(MAX_COST));
      S_SALT: byte_bad = !b64_ok || ((idx == IDX_SALT_LAST) && (b64_val[3:0] != 4'd0));
      S_CTXT: byte_bad = !b64_ok && (idx != IDX_LAST);
      default: byte_bad = 1'b0;
    endcase
  end

  // Parser FSM: slot sequencing, field accumulation, error capture and result packing
  always_ff @(posedge clk or negedge int_rst_l) begin
    if (!int_rst_l) begin
      state     <= S_PFX;
      idx       <= '0;
      cost_acc  <= '0;
      salt_sr   <= '0;
      ctxt_sr   <= '0;
      fin_pend  <= 1'b0;
      fin_bad   <= 1'b0;
      hash_r    <= '0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      err_pos_r <= '0;
      ready_r   <= 1'b1;
    end else if (clr) begin
      state     <= S_PFX;
      idx       <= '0;
      cost_acc  <= '0;
      salt_sr   <= '0;
      ctxt_sr   <= '0;
      fin_pend  <= 1'b0;
      fin_bad   <= 1'b0;
      hash_r    <= '0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      err_pos_r <= '0;
      ready_r   <= 1'b1;
    end else if (fin_pend) begin
      fin_pend <= 1'b0;
      if (fin_bad || (ctxt_sr[1:0] != 2'd0) || (salt_sr[3:0] != 4'd0)) begin
        state     <= S_ERR;
        err_r     <= 1'b1;
        err_pos_r <= IDX_LAST;
      end else begin
        state  <= S_DONE;
        done_r <= 1'b1;
        hash_r <= {cost_acc[5:0], salt_sr[131:4], ctxt_sr[185:2], 8'h00};
      end
    end else if (accept) begin
      idx <= idx + 6'd1;
      if (byte_bad) begin
        state     <= S_ERR;
        err_r     <= 1'b1;
        err_pos_r <= idx;
        ready_r   <= 1'b0;
      end else begin
        case (state)
          S_PFX: begin
            if (idx == IDX_PFX_LAST) state <= S_COST;
          end
          S_COST: begin
            if (idx == IDX_COST_FIRST) cost_acc <= {3'b000, digit};
            else                       cost_acc <= cost_acc * 7'd10 + {3'b000, digit};
            if (idx == IDX_COST_LAST) state <= S_SEP;
          end
          S_SEP: state <= S_SALT;
          S_SALT: begin
            salt_sr <= {salt_sr[125:0], b64_val};
            if (idx == IDX_SALT_LAST) state <= S_CTXT;
          end
          S_CTXT: begin
            ctxt_sr <= {ctxt_sr[179:0], b64_val};
            if (idx == IDX_LAST) begin
              fin_pend <= 1'b1;
              fin_bad  <= !b64_ok;
              ready_r  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready = ready_r;
  assign bus.hash_o   = hash_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;
  assign bus.err_pos  = err_pos_r;

endmodule

// File: tb/tb_bcrypt_hash_parser.sv
// Self-checking bench for bcrypt_hash_parser: vector table, hand sequences, random strings.
module tb_bcrypt_hash_parser;
  import bcrypt_hash_parser_pkg::*;

  typedef byte str_t [60];
  typedef logic [HASH_W-1:0] hw_t;

  typedef struct {
    int  cost;
    int  bad_pos;
    byte bad_ch;
    bit  gappy;
    bit  exp_err;
    int  exp_pos;
  } vec_t;

  localparam logic [127:0] G_SALT = 128'hb9e40330d2c10bbd8bd30cbd0220ceea;
  localparam logic [183:0] G_CTXT = 184'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a69;

  string ALPH = "./0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz";

  logic clk = 1'b0;
  logic int_rst_l;
  logic clr;
  int   n_cmp = 0;
  int   n_bad = 0;

  bcrypt_hash_parser_if bus ();

  bcrypt_hash_parser dut (
    .clk       (clk),
    .int_rst_l (int_rst_l),
    .clr       (clr),
    .bus       (bus)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Hard stop in case a wait escapes its bound
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int alphIdx(input byte c);
    for (int i = 0; i < 64; i++)
      if (ALPH[i] == c) return i;
    return -1;
  endfunction

  // Encode cost/salt/ctext into the 60-char modular-crypt string
  function automatic void buildStr(input int cost, input logic [127:0] salt,
                                   input logic [183:0] ct, output str_t s);
    logic [131:0] sb;
    logic [185:0] cb;
    sb = {salt, 4'b0000};
    cb = {ct, 2'b00};
    s[0] = "$"; s[1] = "2"; s[2] = "a"; s[3] = "$";
    s[4] = byte'(8'h30 + cost / 10);
    s[5] = byte'(8'h30 + cost % 10);
    s[6] = "$";
    for (int k = 0; k < 22; k++) s[7 + k]  = ALPH[int'(sb[131 - 6 * k -: 6])];
    for (int k = 0; k < 31; k++) s[29 + k] = ALPH[int'(cb[185 - 6 * k -: 6])];
  endfunction

  // Reference decoder: walks the string slot by slot, first bad byte wins
  function automatic void refCheck(input str_t s, output bit e, output int p, output hw_t h);
    int           v;
    int           cost;
    bit           ok;
    logic [131:0] sa;
    logic [185:0] ct;
    e = 1'b0; p = 0; h = '0; cost = 0; sa = '0; ct = '0;
    for (int i = 0; i < 60 && !e; i++) begin
      ok = 1'b1;
      if (i == 0 || i == 3)      ok = (s[i] == "$");
      else if (i == 1)           ok = (s[i] == "2");
      else if (i == 2)           ok = (s[i] == "a") || (s[i] == "b");
      else if (i == 4 || i == 5) begin
        ok = (s[i] >= "0") && (s[i] <= "9");
        cost = cost * 10 + (int'(s[i]) - 48);
      end else if (i == 6)       ok = (s[i] == "$") && (cost >= 4) && (cost <= 31);
      else begin
        v  = alphIdx(s[i]);
        ok = (v >= 0);
        if (i <= 28) begin
          sa = {sa[125:0], 6'(v)};
          if (i == 28 && (v % 16) != 0) ok = 1'b0;
        end else begin
          ct = {ct[179:0], 6'(v)};
          if (i == 59 && (v % 4) != 0) ok = 1'b0;
        end
      end
      if (!ok) begin
        e = 1'b1;
        p = i;
      end
    end
    if (!e) h = {6'(cost), sa[131:4], ct[185:2], 8'h00};
  endfunction

  task automatic checkOutput(input string name, input hw_t act, input hw_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Send the first n bytes, optionally with random in_valid gaps; stops early on err
  task automatic applyStimulus(input str_t s, input int n, input bit gappy);
    int sent = 0;
    int cyc  = 0;
    bit rdy;
    while (sent < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus.err) break;
      bus.in_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = s[sent];
      rdy          = bus.in_ready;
      @(posedge clk);
      if (bus.in_valid && rdy) sent++;
    end
    #1 bus.in_valid = 1'b0;
    if (sent < n && !bus.err) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL send_budget: got %0d bytes expected %0d", sent, n);
    end
  endtask

  // Wait (bounded) for done or err; lat counts negedges after the last send step
  task automatic waitResult(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.done || bus.err) break;
    end
    if (!(bus.done || bus.err)) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL result_wait: got no done/err expected one within 20 cycles");
    end
  endtask

  task automatic runVector(input str_t s, input bit gappy, input bit exp_err,
                           input int exp_pos, input string tag);
    bit  me;
    int  mp;
    hw_t h;
    int  lat;
    refCheck(s, me, mp, h);
    applyStimulus(s, 60, gappy);
    waitResult(lat);
    checkOutput({tag, " err"},   hw_t'(bus.err),  hw_t'(exp_err));
    checkOutput({tag, " done"},  hw_t'(bus.done), hw_t'(!exp_err));
    if (exp_err) checkOutput({tag, " err_pos"}, hw_t'(bus.err_pos), hw_t'(exp_pos));
    checkOutput({tag, " hash"},  bus.hash_o, exp_err ? hw_t'(0) : h);
    checkOutput({tag, " ready"}, hw_t'(bus.in_ready), hw_t'(0));
    checkOutput({tag, " lat"},   hw_t'(lat), (!exp_err || exp_pos == 59) ? hw_t'(2) : hw_t'(1));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " idle done"},  hw_t'(bus.done),     hw_t'(0));
    checkOutput({tag, " idle err"},   hw_t'(bus.err),      hw_t'(0));
    checkOutput({tag, " idle pos"},   hw_t'(bus.err_pos),  hw_t'(0));
    checkOutput({tag, " idle hash"},  bus.hash_o,          hw_t'(0));
    checkOutput({tag, " idle ready"}, hw_t'(bus.in_ready), hw_t'(1));
  endtask

  task automatic pulseClr(input string tag);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkIdle(tag);
  endtask

  // Main sequence
  initial begin
    vec_t         vt [14];
    str_t         s;
    str_t         g;
    bit           me;
    int           mp;
    hw_t          mh;
    int           cost;
    logic [127:0] rs;
    logic [183:0] rc;

    //           cost bad  char gap err pos
    vt[0]  = '{4,  -1, "$", 0, 0, 0};
    vt[1]  = '{4,  -1, "$", 1, 0, 0};
    vt[2]  = '{3,  -1, "$", 0, 1, 6};
    vt[3]  = '{4,   5, "x", 0, 1, 5};
    vt[4]  = '{4,   2, "c", 0, 1, 2};
    vt[5]  = '{4,  28, "E", 0, 0, 0};
    vt[6]  = '{4,  28, "F", 0, 1, 28};
    vt[7]  = '{4,  28, "P", 0, 1, 28};
    vt[8]  = '{4,  59, "/", 0, 1, 59};
    vt[9]  = '{4,  40, "+", 0, 1, 40};
    vt[10] = '{4,  -1, "$", 0, 0, 0};
    vt[11] = '{4,   2, "b", 1, 0, 0};
    vt[12] = '{32, -1, "$", 0, 1, 6};
    vt[13] = '{31, -1, "$", 1, 0, 0};

    int_rst_l    = 1'b0;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkIdle("reset");
    int_rst_l = 1'b1;
    @(negedge clk);
    checkIdle("post_reset");

    // Golden string, field slices against the known cost/salt/ctext
    buildStr(4, G_SALT, G_CTXT, g);
    runVector(g, 1'b0, 1'b0, 0, "golden");
    checkOutput("golden cost",  hw_t'(bus.hash_o[325:320]), hw_t'(6'd4));
    checkOutput("golden salt",  hw_t'(bus.hash_o[319:192]), hw_t'(G_SALT));
    checkOutput("golden ctext", hw_t'(bus.hash_o[191:8]),   hw_t'(G_CTXT));
    checkOutput("golden pad",   hw_t'(bus.hash_o[7:0]),     hw_t'(8'h00));
    repeat (3) @(negedge clk);
    checkOutput("golden hold done", hw_t'(bus.done), hw_t'(1));
    pulseClr("golden");

    // Table of corner-case strings
    for (int i = 0; i < 14; i++) begin
      buildStr(vt[i].cost, G_SALT, G_CTXT, s);
      if (vt[i].bad_pos >= 0) s[vt[i].bad_pos] = vt[i].bad_ch;
      runVector(s, vt[i].gappy, vt[i].exp_err, vt[i].exp_pos, $sformatf("vec%0d", i));
      pulseClr($sformatf("vec%0d", i));
    end

    // Async reset after 31 bytes, then a full resend
    applyStimulus(g, 31, 1'b0);
    @(negedge clk);
    int_rst_l = 1'b0;
    #2;
    checkIdle("midreset");
    @(negedge clk);
    int_rst_l = 1'b1;
    runVector(g, 1'b0, 1'b0, 0, "resend");
    pulseClr("resend");

    // clr coinciding with an offered byte: the byte must be discarded
    applyStimulus(g, 10, 1'b0);
    @(negedge clk);
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = "$";
    @(negedge clk);
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    runVector(g, 1'b0, 1'b0, 0, "clr_collide");
    pulseClr("clr_collide");

    // Random strings against the reference decoder
    for (int r = 0; r < 16; r++) begin
      cost = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(4, 31));
      rs   = {$urandom(), $urandom(), $urandom(), $urandom()};
      rc   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      buildStr(cost, rs, rc, s);
      if ($urandom_range(0, 2) == 0)
        s[$urandom_range(0, 59)] = byte'($urandom_range(33, 126));
      refCheck(s, me, mp, mh);
      runVector(s, 1'($urandom_range(0, 1)), me, mp, $sformatf("rand%0d", r));
      pulseClr($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
